// File: rtl/key_event_ctrl_if.sv
// Key event bus: debounced edge events in, gesture event pulses out.
// master = debouncer/stimulus side, slave = key_event_ctrl.
interface key_event_ctrl_if;
    logic key_flag;
    logic key_value;
    logic evt_single;
    logic evt_double;
    logic evt_long;
    logic evt_repeat;
    logic key_held;

    modport master (
        output key_flag,
        output key_value,
        input  evt_single,
        input  evt_double,
        input  evt_long,
        input  evt_repeat,
        input  key_held
    );

    modport slave (
        input  key_flag,
        input  key_value,
        output evt_single,
        output evt_double,
        output evt_long,
        output evt_repeat,
        output key_held
    );
endinterface

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: per-key gesture classifier (single / double / long press).
// Consumes debounced key_flag/key_value edges, emits registered 1-cycle
// event pulses plus a key_held level. All press timing lives here.
// Optional feature: define KEY_REPEAT_EN to enable auto-repeat pulses on
// evt_repeat while a long press is held; otherwise evt_repeat is tied 0.
module key_event_ctrl #(
    parameter int unsigned CNT_W      = 26,
    parameter int unsigned LONG_CYC   = 50_000_000,
    parameter int unsigned DCLICK_CYC = 15_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000
) (
    input logic             clk,
    input logic             rst_n,
    key_event_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG_HOLD
    } state_t;

    localparam int unsigned MAX_CYC_A = (LONG_CYC > DCLICK_CYC) ? LONG_CYC : DCLICK_CYC;
    localparam int unsigned MAX_CYC   = (MAX_CYC_A > REPEAT_CYC) ? MAX_CYC_A : REPEAT_CYC;

    // Timer must be able to reach the longest terminal count.
    if (64'(MAX_CYC) > (64'd1 << CNT_W)) begin : g_cnt_w_check
        $error("key_event_ctrl: CNT_W too narrow for configured cycle counts");
    end

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic             key_press, key_release;
    logic             single_nxt, double_nxt, long_nxt;
`ifdef KEY_REPEAT_EN
    logic             repeat_nxt;
`endif

    assign key_press   = bus.key_flag & ~bus.key_value;
    assign key_release = bus.key_flag &  bus.key_value;

    // Next-state, event decode and timer update; earlier branches take priority.
    always_comb begin
        state_nxt  = state;
        single_nxt = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
`ifdef KEY_REPEAT_EN
        repeat_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (key_press) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (key_release) begin
                    state_nxt = WAIT2;
                end else if (timer == LONG_LAST) begin
                    long_nxt  = 1'b1;
                    state_nxt = LONG_HOLD;
                end
            end
            WAIT2: begin
                if (key_press) begin
                    state_nxt = PRESS2;
                end else if (timer == DCLICK_LAST) begin
                    single_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            PRESS2: begin
                if (key_release) begin
                    double_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            LONG_HOLD: begin
                if (key_release) begin
                    state_nxt = IDLE;
                end
`ifdef KEY_REPEAT_EN
                else if (timer == REPEAT_LAST) begin
                    repeat_nxt = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase

`ifdef KEY_REPEAT_EN
        timer_nxt = ((state_nxt != state) || repeat_nxt) ? '0 : timer + 1'b1;
`else
        timer_nxt = (state_nxt != state) ? '0 : timer + 1'b1;
`endif
    end

    // State, timer and registered outputs; reset aborts any gesture in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            timer          <= '0;
            bus.evt_single <= 1'b0;
            bus.evt_double <= 1'b0;
            bus.evt_long   <= 1'b0;
            bus.key_held   <= 1'b0;
        end else begin
            state          <= state_nxt;
            timer          <= timer_nxt;
            bus.evt_single <= single_nxt;
            bus.evt_double <= double_nxt;
            bus.evt_long   <= long_nxt;
            bus.key_held   <= (state_nxt == PRESS1) || (state_nxt == PRESS2) ||
                              (state_nxt == LONG_HOLD);
        end
    end

`ifdef KEY_REPEAT_EN
    // Auto-repeat pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.evt_repeat <= 1'b0;
        else        bus.evt_repeat <= repeat_nxt;
    end
`else
    assign bus.evt_repeat = 1'b0;
`endif

endmodule
